// File: rtl/fx_pkg.sv
// Shared types and constants for the effect select/start controller.
package fx_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEL   = 3'd1,
    S_SWAP  = 3'd2,
    S_ARM   = 3'd3,
    S_START = 3'd4,
    S_RUN   = 3'd5
  } fx_state_t;

  localparam int FX_PARAM_W  = 2;
  localparam int FX_N_FX_DEF = 4;

endpackage

// File: rtl/fx_onehot_dec.sv
// Registered index-to-one-hot decoder with a synchronous clear, driving the effect select lines.
module fx_onehot_dec #(
  parameter int N_FX  = 4,
  parameter int IDX_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic [IDX_W-1:0] i_idx,
  output logic [N_FX-1:0]  o_sel
);

  logic [N_FX-1:0] w_dec;

  always_comb begin
    w_dec = '0;
    for (int k = 0; k < N_FX; k++) begin
      w_dec[k] = (i_idx == IDX_W'(k));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   o_sel <= '0;
    else if (i_clr) o_sel <= '0;
    else            o_sel <= w_dec;
  end

endmodule

// File: rtl/effect_ctrl.sv
// Initiator for the effect select/start/parameter handshake; all outputs registered from next state.
// Optional select-idle timeout enabled by defining EFFECT_CTRL_TIMEOUT_EN.
module effect_ctrl
  import fx_pkg::*;
#(
  parameter int N_FX        = FX_N_FX_DEF,
  parameter int IDX_W       = 2,
  parameter int SETUP_CYC   = 4,
  parameter int TIMEOUT_CYC = 12000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_key_sel,
  input  logic [IDX_W-1:0]      i_fx_idx,
  input  logic                  i_key_start,
  input  logic                  i_key_stop,
  input  logic [FX_PARAM_W-1:0] i_param_a,
  input  logic [FX_PARAM_W-1:0] i_param_b,
  output logic [N_FX-1:0]       o_sel,
  output logic                  o_start,
  output logic [FX_PARAM_W-1:0] o_param_a,
  output logic [FX_PARAM_W-1:0] o_param_b,
  output logic                  o_busy,
  output logic                  o_run
);

  localparam logic [IDX_W:0] NFX_L    = N_FX[IDX_W:0];
  localparam logic [7:0]     SETUP_LD = 8'(SETUP_CYC - 1);

  fx_state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  logic [7:0]            r_cnt, w_cnt_nxt;
  logic                  r_start, r_busy, r_run;
  logic [FX_PARAM_W-1:0] r_param_a, r_param_b;
  logic                  w_idx_ok, w_sel_clr, w_to_hit;

  assign w_idx_ok = ({1'b0, i_fx_idx} < NFX_L);

`ifdef EFFECT_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0]       r_to_cnt;
  logic [FX_PARAM_W-1:0] r_pa_prev, r_pb_prev;
  logic                  w_activity;

  // Any key or switch movement counts as user activity and restarts the idle count.
  assign w_activity = i_key_sel | i_key_start |
                      (i_param_a != r_pa_prev) | (i_param_b != r_pb_prev);
  assign w_to_hit   = (r_state == S_SEL) && !w_activity &&
                      (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_to_cnt  <= '0;
      r_pa_prev <= '0;
      r_pb_prev <= '0;
    end else begin
      r_pa_prev <= i_param_a;
      r_pb_prev <= i_param_b;
      if (r_state == S_SEL && !w_activity) r_to_cnt <= r_to_cnt + 1'b1;
      else                                 r_to_cnt <= '0;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYC;
  assign w_to_hit         = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (!i_key_stop && !i_key_start && i_key_sel && w_idx_ok) begin
          w_state_nxt = S_SEL;
          w_idx_nxt   = i_fx_idx;
        end
      end
      S_SEL: begin
        if (i_key_stop) begin
          w_state_nxt = S_IDLE;
        end else if (i_key_start) begin
          w_state_nxt = S_ARM;
          w_cnt_nxt   = SETUP_LD;
        end else if (i_key_sel && w_idx_ok && (i_fx_idx != r_idx)) begin
          w_state_nxt = S_SWAP;
          w_idx_nxt   = i_fx_idx;
        end else if (w_to_hit) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SWAP:  w_state_nxt = i_key_stop ? S_IDLE : S_SEL;
      S_ARM: begin
        if (i_key_stop)        w_state_nxt = S_IDLE;
        else if (r_cnt == '0)  w_state_nxt = S_START;
        else                   w_cnt_nxt   = r_cnt - 1'b1;
      end
      S_START: w_state_nxt = S_RUN;
      S_RUN:   if (i_key_stop) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Select drops whenever the next state has no active effect, including the swap gap.
  assign w_sel_clr = (w_state_nxt == S_IDLE) || (w_state_nxt == S_SWAP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_run     <= 1'b0;
      r_param_a <= '0;
      r_param_b <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_start <= (w_state_nxt == S_START);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_run   <= (w_state_nxt == S_RUN);
      // Parameters track the switches only while selected; leaving S_SEL freezes them.
      if (r_state == S_SEL) begin
        r_param_a <= i_param_a;
        r_param_b <= i_param_b;
      end
    end
  end

  fx_onehot_dec #(
    .N_FX  (N_FX),
    .IDX_W (IDX_W)
  ) u_sel_dec (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_sel_clr),
    .i_idx   (w_idx_nxt),
    .o_sel   (o_sel)
  );

  assign o_start   = r_start;
  assign o_busy    = r_busy;
  assign o_run     = r_run;
  assign o_param_a = r_param_a;
  assign o_param_b = r_param_b;

endmodule

// File: tb/tb_effect_ctrl.sv
// Table-driven bench for effect_ctrl with a queue scoreboard plus reset and timeout sequences.
module tb_effect_ctrl;

  localparam int N_FX  = 4;
  localparam int IDX_W = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_sel = 1'b0, key_start = 1'b0, key_stop = 1'b0;
  logic [2:0] fx_idx = '0;
  logic [1:0] param_a = '0, param_b = '0;
  logic [3:0] sel;
  logic       start, busy, run;
  logic [1:0] pa_o, pb_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  effect_ctrl #(
    .N_FX        (N_FX),
    .IDX_W       (IDX_W),
    .SETUP_CYC   (4),
    .TIMEOUT_CYC (100)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_key_sel   (key_sel),
    .i_fx_idx    (fx_idx),
    .i_key_start (key_start),
    .i_key_stop  (key_stop),
    .i_param_a   (param_a),
    .i_param_b   (param_b),
    .o_sel       (sel),
    .o_start     (start),
    .o_param_a   (pa_o),
    .o_param_b   (pb_o),
    .o_busy      (busy),
    .o_run       (run)
  );

  // Packed outputs: {sel[3:0], start, busy, run, param_a[1:0], param_b[1:0]}
  typedef struct packed {
    logic        ks;
    logic [2:0]  idx;
    logic        kst;
    logic        ksp;
    logic [1:0]  pa;
    logic [1:0]  pb;
    logic [10:0] exp;
  } vec_t;

  vec_t        vecs[37];
  logic [10:0] exp_q[$];

  function automatic vec_t mk(input logic ks, input logic [2:0] idx, input logic kst,
                              input logic ksp, input logic [1:0] pa, input logic [1:0] pb,
                              input logic [3:0] esel, input logic est, input logic ebusy,
                              input logic erun, input logic [1:0] epa, input logic [1:0] epb);
    vec_t v;
    v.ks = ks; v.idx = idx; v.kst = kst; v.ksp = ksp; v.pa = pa; v.pb = pb;
    v.exp = {esel, est, ebusy, erun, epa, epb};
    return v;
  endfunction

  function automatic logic [10:0] outs();
    return {sel, start, busy, run, pa_o, pb_o};
  endfunction

  task automatic check(input string nm, input logic [10:0] got, input logic [10:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, got, want);
    end
  endtask

  // One clock: drive at negedge, push expectation, sample after the edge, pop and compare.
  task automatic cyc(input vec_t v, input string nm);
    logic [10:0] e;
    @(negedge clk);
    key_sel = v.ks; fx_idx = v.idx; key_start = v.kst; key_stop = v.ksp;
    param_a = v.pa; param_b = v.pb;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    key_sel = 1'b0; key_start = 1'b0; key_stop = 1'b0;
    e = exp_q.pop_front();
    check(nm, outs(), e);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      key_sel = 1'b0; key_start = 1'b0; key_stop = 1'b0;
    end
  endtask

  initial begin
    vecs[0]  = mk(0,0,0,1, 2,3, 4'h0,0,0,0, 0,0);
    vecs[1]  = mk(0,0,1,0, 2,3, 4'h0,0,0,0, 0,0);
    vecs[2]  = mk(1,5,0,0, 2,3, 4'h0,0,0,0, 0,0);
    vecs[3]  = mk(1,1,0,0, 2,3, 4'h2,0,1,0, 0,0);
    vecs[4]  = mk(0,0,0,0, 2,3, 4'h2,0,1,0, 2,3);
    vecs[5]  = mk(0,0,1,0, 2,3, 4'h2,0,1,0, 2,3);
    vecs[6]  = mk(0,0,0,0, 2,3, 4'h2,0,1,0, 2,3);
    vecs[7]  = mk(0,0,0,0, 1,0, 4'h2,0,1,0, 2,3);
    vecs[8]  = mk(0,0,0,0, 1,0, 4'h2,0,1,0, 2,3);
    vecs[9]  = mk(0,0,0,0, 1,0, 4'h2,1,1,0, 2,3);
    vecs[10] = mk(0,0,0,0, 1,0, 4'h2,0,1,1, 2,3);
    vecs[11] = mk(1,2,1,0, 1,0, 4'h2,0,1,1, 2,3);
    vecs[12] = mk(0,0,0,1, 1,0, 4'h0,0,0,0, 2,3);
    vecs[13] = mk(1,1,0,0, 1,0, 4'h2,0,1,0, 2,3);
    vecs[14] = mk(1,1,0,0, 1,0, 4'h2,0,1,0, 1,0);
    vecs[15] = mk(1,3,0,0, 1,0, 4'h0,0,1,0, 1,0);
    vecs[16] = mk(0,0,0,0, 1,0, 4'h8,0,1,0, 1,0);
    vecs[17] = mk(1,5,0,0, 1,0, 4'h8,0,1,0, 1,0);
    vecs[18] = mk(0,0,1,1, 1,0, 4'h0,0,0,0, 1,0);
    vecs[19] = mk(0,0,0,0, 1,0, 4'h0,0,0,0, 1,0);
    vecs[20] = mk(1,0,0,0, 1,0, 4'h1,0,1,0, 1,0);
    vecs[21] = mk(0,0,1,0, 1,0, 4'h1,0,1,0, 1,0);
    vecs[22] = mk(0,0,0,0, 1,0, 4'h1,0,1,0, 1,0);
    vecs[23] = mk(0,0,0,1, 1,0, 4'h0,0,0,0, 1,0);
    vecs[24] = mk(0,0,0,0, 1,0, 4'h0,0,0,0, 1,0);
    vecs[25] = mk(0,0,0,0, 1,0, 4'h0,0,0,0, 1,0);
    vecs[26] = mk(1,2,0,0, 1,0, 4'h4,0,1,0, 1,0);
    vecs[27] = mk(1,1,0,0, 1,0, 4'h0,0,1,0, 1,0);
    vecs[28] = mk(0,0,0,1, 1,0, 4'h0,0,0,0, 1,0);
    vecs[29] = mk(1,2,0,0, 1,0, 4'h4,0,1,0, 1,0);
    vecs[30] = mk(0,0,1,0, 1,0, 4'h4,0,1,0, 1,0);
    vecs[31] = mk(0,0,0,0, 1,0, 4'h4,0,1,0, 1,0);
    vecs[32] = mk(0,0,0,0, 1,0, 4'h4,0,1,0, 1,0);
    vecs[33] = mk(0,0,0,0, 1,0, 4'h4,0,1,0, 1,0);
    vecs[34] = mk(0,0,0,0, 1,0, 4'h4,1,1,0, 1,0);
    vecs[35] = mk(0,0,0,1, 1,0, 4'h4,0,1,1, 1,0);
    vecs[36] = mk(0,0,0,1, 1,0, 4'h0,0,0,0, 1,0);

    idle_cycles(3);
    check("reset_state", outs(), 11'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 37; i++) cyc(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted mid-ARM: outputs clear without waiting for a clock edge.
    cyc(mk(1,1,0,0, 2,1, 4'h2,0,1,0, 1,0), "rst_seq_sel");
    cyc(mk(0,0,1,0, 2,1, 4'h2,0,1,0, 2,1), "rst_seq_start");
    cyc(mk(0,0,0,0, 2,1, 4'h2,0,1,0, 2,1), "rst_seq_arm");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_async_clear", outs(), 11'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) cyc(mk(0,0,0,0, 2,1, 4'h0,0,0,0, 0,0), $sformatf("post_rst%0d", i));

`ifdef EFFECT_CTRL_TIMEOUT_EN
    cyc(mk(1,1,0,0, 2,1, 4'h2,0,1,0, 0,0), "to_sel");
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      @(posedge clk);
      #1;
      if (k == 99)  check("to_hold99", {7'd0, sel}, {7'd0, 4'h2});
      if (k == 100) check("to_drop100", {7'd0, sel}, 11'd0);
    end
    cyc(mk(1,1,0,0, 2,1, 4'h2,0,1,0, 2,1), "to_sel2");
    for (int k = 1; k <= 160; k++) begin
      @(negedge clk);
      if (k == 60) param_a = 2'd3;
      @(posedge clk);
      #1;
      if (k == 100) check("to_restart100", {7'd0, sel}, {7'd0, 4'h2});
      if (k == 159) check("to_hold159", {7'd0, sel}, {7'd0, 4'h2});
      if (k == 160) check("to_drop160", {7'd0, sel}, 11'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/effect_ctrl.md
Name: effect_ctrl

Overview:
- Initiator side of the effect select/start/parameter handshake used by the pedal effect modules (tremolo and siblings).
- Turns single-cycle key pulses and switch settings into, for each effect: a one-hot select, a one-cycle start strobe and two 2-bit parameter buses.
- Sits between the debounced user-input block and the effect chain.
- Guarantees the parameters are stable at the receiving effect for SETUP_CYC cycles before the start strobe.

Parameters:
- N_FX, 4: number of effect slots; sets the o_sel width.
- IDX_W, 2: width of i_fx_idx; must be at least clog2(N_FX).
- SETUP_CYC, 4: cycles the parameters are frozen with select held before o_start; legal range 1..255.
- TIMEOUT_CYC, 12000000: select-idle timeout in cycles; used only with the optional feature.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  reset
- i_key_sel  in  1  one-cycle pulse: select the effect named by i_fx_idx
- i_fx_idx  in  IDX_W  effect index; sampled on i_key_sel
- i_key_start  in  1  one-cycle pulse: arm and start the selected effect
- i_key_stop  in  1  one-cycle pulse: stop or deselect
- i_param_a  in  2  rate-class parameter from switches
- i_param_b  in  2  depth-class parameter from switches
- o_sel  out  N_FX  one-hot select; all zero when no effect is selected
- o_start  out  1  one-cycle start strobe to the selected effect
- o_param_a  out  2  registered parameter A
- o_param_b  out  2  registered parameter B
- o_busy  out  1  high whenever state is not S_IDLE
- o_run  out  1  high in S_RUN

Behaviour:
- Reset and clocking: reset i_rst_n, asynchronous, active-low; clock i_clk. All outputs reset to 0, state resets to S_IDLE, counters reset to 0.
- Registered outputs: every output is registered. Outputs reflect the state entered on the same clock edge.
- Key priority within one cycle: stop > start > sel. Only the highest-priority key acts.
- S_IDLE: o_sel = 0.
  - i_key_sel with i_fx_idx < N_FX: latch idx, go to S_SEL. o_sel[idx] = 1 from the next cycle.
  - i_key_sel with idx >= N_FX: ignored.
  - Start and stop: ignored.
- S_SEL:
  - o_param_a/b follow i_param_a/b with 1-cycle latency.
  - i_key_stop: go to S_IDLE.
  - i_key_sel with the same idx: no effect.
  - i_key_sel with a different valid idx: go to S_SWAP.
  - i_key_start: go to S_ARM; load the setup counter with SETUP_CYC-1.
- S_SWAP: o_sel = 0 for exactly one cycle, then S_SEL with the new idx. The receiving effect therefore sees its select drop. Stop in S_SWAP goes to S_IDLE.
- S_ARM:
  - o_sel held; o_param_a/b frozen at their values on entry.
  - Counter decrements each cycle. At 0, go to S_START.
  - i_key_stop aborts to S_IDLE. i_key_sel is ignored.
- S_START: o_start = 1 for exactly one cycle; o_sel held. Go to S_RUN unconditionally; a stop in this cycle is applied in S_RUN on a later pulse.
- S_RUN:
  - o_sel held, parameters frozen, o_run = 1.
  - i_key_stop: go to S_IDLE, with o_sel = 0 next cycle.
  - Start and sel pulses are ignored.
- Start-to-strobe timing: with no stop, the cycle after the i_key_start cycle begins S_ARM. o_start rises exactly SETUP_CYC+1 cycles after the i_key_start cycle.
- Reset mid-operation: o_sel and o_start drop asynchronously to 0. No strobe is emitted after reset release until a new sel/start sequence.

Optional Feature:
- Macro: EFFECT_CTRL_TIMEOUT_EN.
- Defined: a timeout counter runs in S_SEL and clears on any i_key_sel, any i_key_start, or any change of i_param_a/b. After TIMEOUT_CYC idle cycles, go to S_IDLE, with o_sel = 0 next cycle.
- Not defined: S_SEL is held indefinitely. No timeout counter is instantiated.

Decomposition:
- Shared package fx_pkg holds:
  - the state enum: S_IDLE, S_SEL, S_SWAP, S_ARM, S_START, S_RUN;
  - the localparams for parameter width (2) and for the default N_FX.
- One sub-module, fx_onehot_dec: registered index-to-one-hot decoder with a clear input, driving o_sel.

Test Plan:
- Reset then idle: all outputs 0. Stop and start pulses in S_IDLE -> o_busy stays 0, o_start never asserts.
- Sel idx=1, params a=2'b10, b=2'b11, start at cycle T, SETUP_CYC=4:
  - o_sel=4'b0010 from the cycle after the sel pulse;
  - o_start high only at T+5;
  - o_param frozen at 10/11 even if the switches change at T+2;
  - o_run=1 from T+6.
- In S_SEL, sel idx=1 then sel idx=3 -> o_sel 0010, then 0000 for one cycle, then 1000. Sel idx=5 with N_FX=4 -> ignored.
- Start and stop in the same cycle during S_SEL -> S_IDLE, o_start never asserts. Stop during S_ARM -> o_sel=0 next cycle, no strobe.
- Assert i_rst_n low during S_ARM -> all outputs 0 immediately. After release, no o_start until a fresh sel+start.
- With EFFECT_CTRL_TIMEOUT_EN and TIMEOUT_CYC=100:
  - sel, then no activity -> o_sel=0 after 100 idle cycles;
  - a param toggle at cycle 60 restarts the count.
